// File: rtl/gobou_ctrl_issue_if.sv
// Gobou control bus: start/valid/stop strobes between
// the issue block and the ctrl pipeline chain.
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;

    modport master (output start, valid, stop);
    modport slave  (input  start, valid, stop);
endinterface

// File: rtl/gobou_ctrl_issue.sv
// Issue end of the gobou ctrl chain: sequences start/valid/stop
// per batch, generates read addresses, acks once all stops return.
module gobou_ctrl_issue #(
    parameter int LWIDTH  = 16,
    parameter int IWIDTH  = 12,
    parameter int WWIDTH  = 16,
    parameter int CORE    = 16,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [LWIDTH-1:0] n_in,
    input  logic [LWIDTH-1:0] n_out,
    output logic              ack,
    output logic              busy,
    ctrl_bus.master           out_ctrl,
    ctrl_bus.slave            tail_ctrl,
    output logic [IWIDTH-1:0] in_addr,
    output logic [WWIDTH-1:0] w_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ISSUE,
        S_GAP,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [LWIDTH:0]   CORE_W   = (LWIDTH+1)'(CORE);
    localparam logic [LWIDTH:0]   CORE_M1  = (LWIDTH+1)'(CORE - 1);
    localparam logic [LWIDTH:0]   ONE_B    = (LWIDTH+1)'(1);
    localparam logic [LWIDTH-1:0] ONE_L    = LWIDTH'(1);
    localparam logic [LWIDTH-1:0] GAP_LAST = LWIDTH'(GAP_CYC - 1);

    state_e              state_q, state_d;
    logic [LWIDTH-1:0]   n_in_q, n_in_d;
    logic [LWIDTH:0]     batches_q, batches_d;
    logic [LWIDTH-1:0]   batch_q, batch_d;
    logic [LWIDTH-1:0]   in_cnt_q, in_cnt_d;
    logic [LWIDTH-1:0]   ret_q, ret_d;
    logic [LWIDTH-1:0]   gap_q, gap_d;
    logic [WWIDTH-1:0]   base_q, base_d;

    logic                start_q, start_d;
    logic                valid_q, valid_d;
    logic                stop_q, stop_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [IWIDTH-1:0]   in_addr_q, in_addr_d;
    logic [WWIDTH-1:0]   w_addr_q, w_addr_d;

    logic [LWIDTH:0]     batches_calc;
    logic                last_in;
    logic                last_batch;

    assign batches_calc = ({1'b0, n_out} + CORE_M1) / CORE_W;
    assign last_in      = (in_cnt_q == n_in_q - ONE_L);
    assign last_batch   = (({1'b0, batch_q} + ONE_B) == batches_q);

    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q   <= S_IDLE;
            n_in_q    <= '0;
            batches_q <= '0;
            batch_q   <= '0;
            in_cnt_q  <= '0;
            ret_q     <= '0;
            gap_q     <= '0;
            base_q    <= '0;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            stop_q    <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_in_q    <= n_in_d;
            batches_q <= batches_d;
            batch_q   <= batch_d;
            in_cnt_q  <= in_cnt_d;
            ret_q     <= ret_d;
            gap_q     <= gap_d;
            base_q    <= base_d;
            start_q   <= start_d;
            valid_q   <= valid_d;
            stop_q    <= stop_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            in_addr_q <= in_addr_d;
            w_addr_q  <= w_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_in_d    = n_in_q;
        batches_d = batches_q;
        batch_d   = batch_q;
        in_cnt_d  = in_cnt_q;
        ret_d     = ret_q;
        gap_d     = gap_q;
        base_d    = base_q;
        // Short chains may return stops before issue has finished.
        if (state_q != S_IDLE && tail_ctrl.stop) begin
            ret_d = ret_q + ONE_L;
        end
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    n_in_d    = n_in;
                    batches_d = batches_calc;
                    batch_d   = '0;
                    in_cnt_d  = '0;
                    ret_d     = '0;
                    base_d    = '0;
                    if (n_in == '0 || n_out == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                in_cnt_d = '0;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                in_cnt_d = in_cnt_q + ONE_L;
                if (last_in) begin
                    in_cnt_d = '0;
                    batch_d  = batch_q + ONE_L;
                    base_d   = base_q + WWIDTH'(n_in_q);
                    if (last_batch) begin
                        state_d = S_WAIT;
                    end else if (GAP_CYC == 0) begin
                        state_d = S_START;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q + ONE_L;
                if (gap_q == GAP_LAST) begin
                    state_d = S_START;
                end
            end
            S_WAIT: begin
                if ({1'b0, ret_d} == batches_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        start_d   = (state_q == S_START);
        valid_d   = (state_q == S_ISSUE);
        stop_d    = valid_d && last_in;
        ack_d     = (state_q == S_DONE);
        busy_d    = (state_q != S_IDLE);
        in_addr_d = '0;
        w_addr_d  = '0;
        if (valid_d) begin
            in_addr_d = IWIDTH'(in_cnt_q);
            w_addr_d  = base_q + WWIDTH'(in_cnt_q);
        end
    end

    assign out_ctrl.start = start_q;
    assign out_ctrl.valid = valid_q;
    assign out_ctrl.stop  = stop_q;
    assign ack            = ack_q;
    assign busy           = busy_q;
    assign in_addr        = in_addr_q;
    assign w_addr         = w_addr_q;

endmodule

// File: tb/tb_gobou_ctrl_issue.sv
// Bench for gobou_ctrl_issue: expected bus events are queued by
// the stimulus thread and matched by a negedge monitor.
module tb_gobou_ctrl_issue;

    logic        clk = 1'b0;
    logic        xrst;
    logic        req;
    logic [15:0] n_in;
    logic [15:0] n_out;
    logic        ack;
    logic        busy;
    logic [11:0] in_addr;
    logic [15:0] w_addr;
    logic        loop_mode;
    logic        tail_drv;

    ctrl_bus out_if ();
    ctrl_bus tail_if ();

    assign tail_if.start = 1'b0;
    assign tail_if.valid = 1'b0;
    assign tail_if.stop  = loop_mode ? out_if.stop : tail_drv;

    gobou_ctrl_issue dut (
        .clk      (clk),
        .xrst     (xrst),
        .req      (req),
        .n_in     (n_in),
        .n_out    (n_out),
        .ack      (ack),
        .busy     (busy),
        .out_ctrl (out_if),
        .tail_ctrl(tail_if),
        .in_addr  (in_addr),
        .w_addr   (w_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        s;
        logic        v;
        logic        p;
        logic        a;
        logic [11:0] ia;
        logic [15:0] wa;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(string nm, int got, int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    task automatic push(int c, bit s, bit v, bit p, bit a, int ia, int wa);
        ev_t x;
        x.c  = c;
        x.s  = s;
        x.v  = v;
        x.p  = p;
        x.a  = a;
        x.ia = 12'(ia);
        x.wa = 16'(wa);
        q.push_back(x);
    endtask

    task automatic push_batch(int c0, int n, int wbase);
        push(c0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) begin
            push(c0 + 1 + k, 0, 1, k == n - 1, 0, k, wbase + k);
        end
    endtask

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_req(int ni, int no);
        n_in  = 16'(ni);
        n_out = 16'(no);
        req   = 1'b1;
        @(negedge clk);
        req   = 1'b0;
    endtask

    task automatic tail_at(int edge_n);
        wait_to(edge_n - 1);
        tail_drv = 1'b1;
        @(negedge clk);
        tail_drv = 1'b0;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_ev @%0d got none want@%0d", cyc, q[0].c);
            e = q.pop_front();
        end
        if (out_if.start | out_if.valid | out_if.stop | ack) begin
            total++;
            if (q.size() == 0 || q[0].c != cyc) begin
                bad++;
                $display("FAIL unexpected_ev @%0d got s%b v%b p%b a%b want none",
                         cyc, out_if.start, out_if.valid, out_if.stop, ack);
            end else begin
                e = q.pop_front();
                if ({out_if.start, out_if.valid, out_if.stop, ack,
                     in_addr, w_addr} !==
                    {e.s, e.v, e.p, e.a, e.ia, e.wa}) begin
                    bad++;
                    $display("FAIL ev @%0d got s%b v%b p%b a%b ia%0d wa%0d want s%b v%b p%b a%b ia%0d wa%0d",
                             cyc, out_if.start, out_if.valid, out_if.stop, ack,
                             in_addr, w_addr, e.s, e.v, e.p, e.a, e.ia, e.wa);
                end
            end
        end
    end

    int t0;

    initial begin
        xrst      = 1'b1;
        req       = 1'b0;
        n_in      = '0;
        n_out     = '0;
        loop_mode = 1'b0;
        tail_drv  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", int'(out_if.start), 0);
        chk("rst_valid", int'(out_if.valid), 0);
        chk("rst_stop", int'(out_if.stop), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_addr", int'(in_addr), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        xrst = 1'b0;
        repeat (2) @(negedge clk);

        // T1 single batch
        t0 = cyc + 1;
        push_batch(t0 + 1, 3, 0);
        push(t0 + 11, 0, 0, 0, 1, 0, 0);
        pulse_req(3, 16);
        wait_to(t0 + 5);
        chk("t1_busy_wait", int'(busy), 1);
        tail_at(t0 + 10);
        wait_to(t0 + 11);
        chk("t1_busy_ack", int'(busy), 1);
        wait_to(t0 + 12);
        chk("t1_busy_fall", int'(busy), 0);
        wait_to(t0 + 14);

        // T2 two batches with gap
        t0 = cyc + 1;
        push_batch(t0 + 1, 3, 0);
        push_batch(t0 + 7, 3, 3);
        push(t0 + 15, 0, 0, 0, 1, 0, 0);
        pulse_req(3, 20);
        tail_at(t0 + 6);
        tail_at(t0 + 14);
        wait_to(t0 + 17);

        // T3 zero sizes
        t0 = cyc + 1;
        push(t0 + 1, 0, 0, 0, 1, 0, 0);
        pulse_req(0, 8);
        wait_to(t0 + 1);
        chk("t3_busy_on", int'(busy), 1);
        wait_to(t0 + 2);
        chk("t3_busy_off", int'(busy), 0);
        t0 = cyc + 1;
        push(t0 + 1, 0, 0, 0, 1, 0, 0);
        pulse_req(5, 0);
        wait_to(t0 + 4);

        // T4 zero-delay chain, then spurious idle tail stop
        loop_mode = 1'b1;
        t0 = cyc + 1;
        push_batch(t0 + 1, 3, 0);
        push_batch(t0 + 7, 3, 3);
        push(t0 + 12, 0, 0, 0, 1, 0, 0);
        pulse_req(3, 20);
        wait_to(t0 + 15);
        loop_mode = 1'b0;
        tail_at(cyc + 2);
        wait_to(cyc + 2);
        chk("t4_idle_busy", int'(busy), 0);

        // T5 reset in the middle of issue
        t0 = cyc + 1;
        push(t0 + 1, 1, 0, 0, 0, 0, 0);
        push(t0 + 2, 0, 1, 0, 0, 0, 0);
        pulse_req(4, 16);
        wait_to(t0 + 2);
        xrst = 1'b1;
        @(negedge clk);
        xrst = 1'b0;
        chk("t5_valid_rst", int'(out_if.valid), 0);
        chk("t5_busy_rst", int'(busy), 0);
        wait_to(t0 + 14);
        t0 = cyc + 1;
        push_batch(t0 + 1, 2, 0);
        push(t0 + 7, 0, 0, 0, 1, 0, 0);
        pulse_req(2, 16);
        tail_at(t0 + 6);
        wait_to(t0 + 10);

        // T6 held req re-triggers; pulses while busy are dropped
        loop_mode = 1'b1;
        t0 = cyc + 1;
        push_batch(t0 + 1, 1, 0);
        push(t0 + 4, 0, 0, 0, 1, 0, 0);
        push_batch(t0 + 6, 1, 0);
        push(t0 + 9, 0, 0, 0, 1, 0, 0);
        n_in  = 16'd1;
        n_out = 16'd16;
        req   = 1'b1;
        wait_to(t0 + 5);
        req = 1'b0;
        chk("t6_busy_gap", int'(busy), 0);
        wait_to(t0 + 6);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_to(t0 + 8);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_to(t0 + 16);
        chk("t6_busy_end", int'(busy), 0);
        loop_mode = 1'b0;

        chk("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
